// File: rtl/mem_wb_stage_pkg.sv
// Shared types and constants for the memory/writeback stage: FSM state
// encoding, load/store size codes and the misalignment rule.
package mem_wb_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte accesses are never misaligned; any funct3 not decoded as byte or
   // half is a word access.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
      logic mis;
      case (f3)
         F3_B, F3_BU: mis = 1'b0;
         F3_H, F3_HU: mis = lo[0];
         default:     mis = (lo != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/mem_wb_stage_align.sv
// mem_align: combinational byte-lane logic, store lane insert (byte enables,
// replicated write data) and load lane extract with sign/zero extension.
module mem_align
   import mem_wb_stage_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] load_data
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   always_comb begin
      be    = 4'b1111;
      wdata = store_data;
      case (funct3)
         F3_B: begin
            be    = 4'b0001 << addr_lo;
            wdata = {4{store_data[7:0]}};
         end
         F3_H: begin
            be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata = {2{store_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = store_data;
         end
      endcase
   end

   always_comb begin
      lane_byte = load_word[7:0];
      case (addr_lo)
         2'd0:    lane_byte = load_word[7:0];
         2'd1:    lane_byte = load_word[15:8];
         2'd2:    lane_byte = load_word[23:16];
         default: lane_byte = load_word[31:24];
      endcase
      lane_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];
   end

   always_comb begin
      load_data = load_word;
      case (funct3)
         F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
         F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
         F3_BU:   load_data = {24'd0, lane_byte};
         F3_HU:   load_data = {16'd0, lane_half};
         default: load_data = load_word;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: issues one data-memory access per load/store and
// retires results to the register file. Build option MEM_WB_MISALIGN_CHK_EN
// adds misaligned-access detection and the misalign_o pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a new EX result; ALU results retire from here
// REQ     | dmem_req_o held with stable address/data until dmem_gnt_i
// WAIT    | load granted, waiting for dmem_rvalid_i
module mem_wb_stage
   import mem_wb_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid_i,
   output logic        ex_ready_o,
   input  logic        ex_is_load_i,
   input  logic        ex_is_store_i,
   input  logic [2:0]  ex_funct3_i,
   input  logic        ex_wb_en_i,
   input  logic [4:0]  ex_rd_i,
   input  logic [31:0] ex_alu_res_i,
   input  logic [31:0] ex_store_data_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o,
   output logic        reg_write_en_o
`ifdef MEM_WB_MISALIGN_CHK_EN
   ,
   output logic        misalign_o
`endif
);

   state_t      state_q, state_d;
   logic        is_load_q;
   logic [2:0]  funct3_q;
   logic [4:0]  rd_q;
   logic [31:0] addr_q;
   logic [31:0] sdata_q;

   logic        wr_en_q;
   logic [4:0]  waddr_q;
   logic [31:0] wdata_q;

   logic        accept;
   logic        is_mem;
   logic        mis;
   logic        load_done;
   logic        req;
   logic [3:0]  be_w;
   logic [31:0] wdata_w;
   logic [31:0] load_ext;

   mem_align u_align (
      .funct3     (funct3_q),
      .addr_lo    (addr_q[1:0]),
      .store_data (sdata_q),
      .load_word  (dmem_rdata_i),
      .be         (be_w),
      .wdata      (wdata_w),
      .load_data  (load_ext)
   );

   always_comb begin
      accept = ex_valid_i & (state_q == ST_IDLE);
      is_mem = ex_is_load_i | ex_is_store_i;
      mis    = 1'b0;
`ifdef MEM_WB_MISALIGN_CHK_EN
      mis    = is_mem & is_misaligned(ex_funct3_i, ex_alu_res_i[1:0]);
`endif
      // A response arriving together with the grant completes the load at once.
      load_done = ((state_q == ST_REQ) & dmem_gnt_i & dmem_rvalid_i & is_load_q) |
                  ((state_q == ST_WAIT) & dmem_rvalid_i);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && is_mem && !mis)
               state_d = ST_REQ;
         end
         ST_REQ: begin
            if (dmem_gnt_i) begin
               if (!is_load_q || dmem_rvalid_i)
                  state_d = ST_IDLE;
               else
                  state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid_i)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         is_load_q <= 1'b0;
         funct3_q  <= 3'd0;
         rd_q      <= 5'd0;
         addr_q    <= 32'd0;
         sdata_q   <= 32'd0;
         wr_en_q   <= 1'b0;
         waddr_q   <= 5'd0;
         wdata_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         wr_en_q <= 1'b0;
         if (accept) begin
            is_load_q <= ex_is_load_i;
            funct3_q  <= ex_funct3_i;
            rd_q      <= ex_rd_i;
            addr_q    <= ex_alu_res_i;
            sdata_q   <= ex_store_data_i;
         end
         if (accept && !is_mem) begin
            wr_en_q <= ex_wb_en_i & (ex_rd_i != 5'd0);
            waddr_q <= ex_rd_i;
            wdata_q <= ex_alu_res_i;
         end else if (load_done) begin
            wr_en_q <= (rd_q != 5'd0);
            waddr_q <= rd_q;
            wdata_q <= load_ext;
         end
      end
   end

`ifdef MEM_WB_MISALIGN_CHK_EN
   logic misalign_q;

   always_ff @(posedge clk) begin
      if (!rst)
         misalign_q <= 1'b0;
      else
         misalign_q <= accept & mis;
   end

   assign misalign_o = misalign_q;
`endif

   assign req            = (state_q == ST_REQ);
   assign ex_ready_o     = (state_q == ST_IDLE);
   assign dmem_req_o     = req;
   assign dmem_we_o      = req & ~is_load_q;
   assign dmem_be_o      = req ? be_w : 4'b0000;
   assign dmem_addr_o    = {addr_q[31:2], 2'b00};
   assign dmem_wdata_o   = wdata_w;
   assign reg_write_en_o = wr_en_q;
   assign reg_waddr_o    = waddr_q;
   assign reg_wdata_o    = wdata_q;

endmodule
